// File: rtl/reg_skid_buf_rst_y.sv
// Two-entry skid buffer cutting the ready path between pipeline stages.
// Latency: 1 cycle from input acceptance to o_valid/o_data; 1 word/cycle sustained.
// Backpressure: o_ready is registered-state only, so one extra word lands in r_skid after i_ready drops.
module reg_skid_buf_rst_y #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] r_main, r_main_nxt;
    logic [DATA_WIDTH-1:0] r_skid, r_skid_nxt;
    logic                  in_xfer;
    logic                  out_xfer;

    assign o_valid  = (state != EMPTY);
    assign o_ready  = (state != FULL) && !i_rst;
    assign o_data   = r_main;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    always_comb begin
        case (state)
            BUSY:    o_count = 2'd1;
            FULL:    o_count = 2'd2;
            default: o_count = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        r_main_nxt = r_main;
        r_skid_nxt = r_skid;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    r_main_nxt = i_data;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    r_main_nxt = i_data;
                end else if (in_xfer) begin
                    // Consumer stalled: park the word so o_ready can fall next cycle.
                    r_skid_nxt = i_data;
                    state_nxt  = FULL;
                end else if (out_xfer) begin
                    state_nxt  = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    r_main_nxt = r_skid;
                    state_nxt  = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= EMPTY;
            r_main <= '0;
            r_skid <= '0;
        end else begin
            state  <= state_nxt;
            r_main <= r_main_nxt;
            r_skid <= r_skid_nxt;
        end
    end

endmodule

// File: tb/tb_reg_skid_buf_rst_y.sv
// Directed bench for reg_skid_buf_rst_y: stimulus queues expected words, a monitor pops on each output transfer.
module tb_reg_skid_buf_rst_y;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_ready;
    logic [1:0]  o_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    reg_skid_buf_rst_y #(.DATA_WIDTH(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit expect_out);
        i_valid = 1'b1;
        i_data  = d;
        if (expect_out) exp_q.push_back(d);
    endtask

    // Output-side scoreboard: every transfer on the downstream port consumes one expected word.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %h expected no word at %0t", o_data, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL out_order: got %h expected %h at %0t", o_data, e, $time);
                end
            end
        end
    end

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hDEADBEEF;
        i_ready = 1'b0;

        // Reset held two cycles with a word offered upstream.
        tick();
        chk("rst_ready0", 32'(o_ready), 32'd0);
        tick();
        chk("rst_ready1", 32'(o_ready), 32'd0);
        chk("rst_valid",  32'(o_valid), 32'd0);
        chk("rst_data",   o_data,       32'h0);
        chk("rst_count",  32'(o_count), 32'd0);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("rel_ready",  32'(o_ready), 32'd1);

        // Streaming with the consumer always ready.
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        send(32'hFFFF0000, 1'b1);
        tick();
        chk("str_valid0", 32'(o_valid), 32'd1);
        chk("str_data0",  o_data,       32'hFFFF0000);
        chk("str_cnt0",   32'(o_count), 32'd1);
        send(32'hFFFF00FF, 1'b1);
        tick();
        chk("str_data1",  o_data,       32'hFFFF00FF);
        chk("str_cnt1",   32'(o_count), 32'd1);
        send(32'hFFFFFFFF, 1'b1);
        tick();
        chk("str_data2",  o_data,       32'hFFFFFFFF);
        chk("str_cnt2",   32'(o_count), 32'd1);
        chk("str_valid2", 32'(o_valid), 32'd1);
        i_valid = 1'b0;
        tick();
        chk("str_empty",  32'(o_valid), 32'd0);

        // Backpressure fill, third word held off.
        i_ready = 1'b0;
        send(32'h00000001, 1'b1);
        tick();
        chk("bp_cnt1",    32'(o_count), 32'd1);
        chk("bp_ready1",  32'(o_ready), 32'd1);
        send(32'h00000002, 1'b1);
        tick();
        chk("bp_cnt2",    32'(o_count), 32'd2);
        chk("bp_ready2",  32'(o_ready), 32'd0);
        chk("bp_data2",   o_data,       32'h00000001);
        send(32'h00000003, 1'b0);
        tick();
        chk("bp_hold_cnt",   32'(o_count), 32'd2);
        chk("bp_hold_ready", 32'(o_ready), 32'd0);
        chk("bp_hold_data",  o_data,       32'h00000001);
        tick();
        chk("bp_stable",  o_data,       32'h00000001);

        // Drain from FULL; word 3 enters once o_ready returns.
        i_ready = 1'b1;
        exp_q.push_back(32'h00000003);
        tick();
        chk("dr_data2",   o_data,       32'h00000002);
        chk("dr_ready",   32'(o_ready), 32'd1);
        chk("dr_cnt",     32'(o_count), 32'd1);
        tick();
        chk("dr_data3",   o_data,       32'h00000003);
        chk("dr_cnt3",    32'(o_count), 32'd1);
        i_valid = 1'b0;
        tick();
        chk("dr_empty",   32'(o_valid), 32'd0);

        // Simultaneous in/out while BUSY.
        i_ready = 1'b0;
        send(32'hA5A5A5A5, 1'b1);
        tick();
        i_valid = 1'b0;
        tick();
        chk("sim_data0",  o_data,       32'hA5A5A5A5);
        chk("sim_cnt0",   32'(o_count), 32'd1);
        i_ready = 1'b1;
        send(32'h5A5A5A5A, 1'b1);
        tick();
        chk("sim_data1",  o_data,       32'h5A5A5A5A);
        chk("sim_cnt1",   32'(o_count), 32'd1);
        i_valid = 1'b0;
        tick();
        chk("sim_empty",  32'(o_count), 32'd0);

        // Reset while FULL discards held words.
        i_ready = 1'b0;
        send(32'h00000011, 1'b0);
        tick();
        send(32'h00000022, 1'b0);
        tick();
        chk("mr_full",    32'(o_count), 32'd2);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        #1;
        chk("mr_ready",   32'(o_ready), 32'd0);
        tick();
        chk("mr_valid",   32'(o_valid), 32'd0);
        chk("mr_cnt",     32'(o_count), 32'd0);
        chk("mr_data",    o_data,       32'h0);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        tick();
        tick();
        chk("mr_idle",    32'(o_valid), 32'd0);

        // Recovery after reset.
        send(32'h00000077, 1'b1);
        tick();
        chk("rec_data",   o_data,       32'h00000077);
        i_valid = 1'b0;
        tick();
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
